// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display output block.
package display_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [0:15][6:0] HEX_SEG = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/display_hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/display_out.sv
// Scanned common-anode hex display with frame-aligned commit of CPU writes.
// Optional DISP_BLINK_EN adds per-digit blink driven by a frame counter.
module display_out
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_mask,
`ifdef DISP_BLINK_EN
    input  logic [DIGITS-1:0]     wr_blink,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                frame_end;
    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                commit;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_mask;
    logic [4*DIGITS-1:0] disp_data;
    logic [DIGITS-1:0]   disp_mask;
    logic [3:0]          nibble;
    logic [6:0]          hex_seg;
    logic                blank;

    assign tick      = (div == DIV_MAX);
    assign frame_end = tick && (idx == IDX_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            idx <= '0;
        end else if (tick) begin
            div <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (wr_valid) state_nx = ST_PENDING;
            ST_PENDING: if (frame_end) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state == ST_IDLE);
    end

    assign accept = wr_valid && wr_ready;
    assign commit = (state == ST_PENDING) && frame_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_data <= '0;
            pend_mask <= '0;
            disp_data <= '0;
            disp_mask <= '0;
        end else begin
            if (accept) begin
                pend_data <= wr_data;
                pend_mask <= wr_mask;
            end
            if (commit) begin
                disp_data <= pend_data;
                disp_mask <= pend_mask;
            end
        end
    end

`ifdef DISP_BLINK_EN
    logic [DIGITS-1:0] pend_blink;
    logic [DIGITS-1:0] disp_blink;
    logic [7:0]        frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_blink <= '0;
            disp_blink <= '0;
            frame_cnt  <= '0;
        end else begin
            if (accept) pend_blink <= wr_blink;
            if (commit) disp_blink <= pend_blink;
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Blink digits go dark during the upper half of the 256-frame cycle.
    assign blank = !disp_mask[idx] || (disp_blink[idx] && frame_cnt[7]);
`else
    assign blank = !disp_mask[idx];
`endif

    assign nibble = disp_data[idx*4 +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= blank ? SEG_BLANK : hex_seg;
        end
    end

endmodule

// File: tb/tb_display_out.sv
// Self-checking bench for display_out with SCAN_DIV=4, DIGITS=4.
module tb_display_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
`ifdef DISP_BLINK_EN
    logic [3:0]  wr_blink;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_out #(.SCAN_DIV(4), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
`ifdef DISP_BLINK_EN
        .wr_blink (wr_blink),
`endif
        .an       (an),
        .seg      (seg)
    );

    function automatic logic [6:0] hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle number since reset release determines slot and frame end.
    int          cyc = 0;
    bit          started = 0;
    bit          m_pend;
    logic [15:0] m_pdata, m_disp;
    logic [3:0]  m_pmask, m_dmask;
    logic [3:0]  m_pblink, m_dblink;
    logic [7:0]  m_frames;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_ready;

    always @(posedge clk) begin : model
        int slot;
        bit fe;
        bit blank;
        logic [3:0] one;
        if (!rst) begin
            cyc = 0; m_pend = 0; m_disp = 0; m_dmask = 0; m_dblink = 0;
            m_pdata = 0; m_pmask = 0; m_pblink = 0; m_frames = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_ready = 1'b1;
        end else begin
            slot = (cyc / 4) % 4;
            fe = (cyc % 16) == 15;
            one = 4'b0001 << slot;
            exp_an = ~one;
            blank = !m_dmask[slot] || (m_dblink[slot] && m_frames[7]);
            exp_seg = blank ? 7'h7F : hex(4'((m_disp >> (4 * slot)) & 16'hF));
            if (m_pend && fe) begin
                m_disp = m_pdata; m_dmask = m_pmask; m_dblink = m_pblink;
                m_pend = 0;
            end else if (!m_pend && wr_valid) begin
                m_pdata = wr_data; m_pmask = wr_mask; m_pend = 1;
`ifdef DISP_BLINK_EN
                m_pblink = wr_blink;
`else
                m_pblink = 4'h0;
`endif
            end
            if (fe) m_frames = m_frames + 8'd1;
            exp_ready = !m_pend;
            cyc++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("an", 16'(an), 16'(exp_an));
            check("seg", 16'(seg), 16'(exp_seg));
            check("wr_ready", 16'(wr_ready), 16'(exp_ready));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 16'(wr_ready), 16'h1);
    endtask

    task automatic align(input int phase);
        int n = 0;
        while ((cyc % 16) != phase && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("align", 16'(cyc % 16), 16'(phase));
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] m);
        wait_ready();
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mask  = m;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Literal expectations for each digit over one full frame.
    task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] lit [4];
        bit seen [4];
        logic [3:0] pat;
        lit = '{s0, s1, s2, s3};
        seen = '{0, 0, 0, 0};
        repeat (16) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                pat = ~(4'b0001 << d);
                if (an === pat) begin
                    seen[d] = 1;
                    check($sformatf("scan_seg%0d", d), 16'(seg), 16'(lit[d]));
                end
            end
        end
        for (int d = 0; d < 4; d++)
            check($sformatf("scan_seen%0d", d), 16'(seen[d]), 16'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
`ifdef DISP_BLINK_EN
        wr_blink = '0;
`endif
        repeat (3) begin
            @(negedge clk);
            check("an_in_reset", 16'(an), 16'hF);
        end
        rst = 1'b1;
        check("ready_after_reset", 16'(wr_ready), 16'h1);
        check_scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);

        do_write(16'h1A8F, 4'hF);
        wait_ready();
        check_scan(7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001);

        align(0);
        do_write(16'h0000, 4'hF);
        wr_valid = 1'b1;
        wr_data  = 16'h8888;
        repeat (3) begin
            check("ready_low_pending", 16'(wr_ready), 16'h0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_ready();
        check_scan(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
        do_write(16'h8888, 4'hF);
        wait_ready();
        check_scan(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);

        wait_ready();
        align(15);
        wr_valid = 1'b1;
        wr_data  = 16'hABCD;
        wr_mask  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (wr_ready === 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_latency", 16'(n), 16'd16);
        check_scan(7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000);

        do_write(16'h1234, 4'b0101);
        wait_ready();
        check_scan(7'b0011001, 7'h7F, 7'b0100100, 7'h7F);

        wait_ready();
        align(0);
        do_write(16'hFFFF, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("an_mid_reset", 16'(an), 16'hF);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 16'(wr_ready), 16'h1);
        check_scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);

`ifdef DISP_BLINK_EN
        wr_blink = 4'b0001;
        do_write(16'h0000, 4'hF);
        wr_blink = 4'b0000;
        repeat (2100) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_out.md
# display_out

Board-level output peripheral for the RV32 dev platform. It is the CPU-to-board counterpart of the switch/button input path. The CPU writes a 16-bit value over a valid/ready handshake, and the block shows it as four hex digits on a time-multiplexed common-anode 7-segment display. New values are committed only at scan-frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- DIGITS, 4: number of digits; wr_data width is 4×DIGITS.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-low reset. It is sampled on clk, and 0 resets the block.
- wr_valid  in  1  write request.
- wr_ready  out  1  block can accept a write.
- wr_data  in  4×DIGITS  hex nibbles; nibble i drives digit i (digit 0 is rightmost).
- wr_mask  in  DIGITS  per-digit enable; 0 blanks that digit.
- an  out  DIGITS  anode select, active-low, one-hot-low when driving.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Scan counter:** div counts 0..SCAN_DIV-1, then wraps.
  - tick = (div == SCAN_DIV-1).
  - On tick, idx advances 0..DIGITS-1 and wraps.
  - frame_end = tick && idx == DIGITS-1.
- **Registers:**
  - pend_data/pend_mask (pending)
  - disp_data/disp_mask (displayed)
- **FSM IDLE:**
  - wr_ready = 1.
  - When wr_valid && wr_ready, capture wr_data/wr_mask into pend and go to PENDING.
- **FSM PENDING:**
  - wr_ready = 0, and writes are ignored.
  - On frame_end, copy pend to disp and go to IDLE.
- **Segment drive:**
  - an = ~(1 << idx).
  - seg = hex7seg(disp_data nibble idx).
  - If disp_mask[idx] == 0, seg = 7'h7F, and an still scans.
- **Hex encoding (active-low):** 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110. The rest follow the standard pattern.
- **Reset values:**
  - an = all 1s, seg = 7'h7F, wr_ready = 1.
  - div = 0, idx = 0, FSM = IDLE.
  - pend/disp data and mask = 0, so the display is blank after reset.

## Timing
- an and seg are registered. They update exactly one clk after the tick that changes idx, or one clk after the disp update.
- **Write acceptance:** the write is accepted in the cycle where wr_valid && wr_ready. wr_ready is 0 starting the next cycle.
- **Commit:** disp updates on the first frame_end strictly after acceptance.
  - A write accepted in the same cycle as a frame_end waits for the following frame_end.
  - Latency from acceptance to disp update is therefore 1..DIGITS×SCAN_DIV cycles. The new value first appears on an/seg one cycle after that.
- wr_ready returns to 1 in the cycle after the commit.
- A write presented while wr_ready = 0 is not captured. The master must hold wr_valid.
- **Reset mid-PENDING:** the pending value is discarded, the display blanks, and wr_ready = 1 the cycle after reset is released.
- The display's refresh period is DIGITS×SCAN_DIV cycles.

## Configuration
- **DISP_BLINK_EN defined:**
  - Adds input wr_blink (DIGITS bits), which is captured and committed alongside wr_mask.
  - Adds an 8-bit frame counter that increments on frame_end and resets to 0.
  - A digit with blink set shows as blank while frame counter bit 7 == 1.
  - Reset value of the blink register is 0.
- **Not defined:** there is no wr_blink port and no frame counter, and behaviour is exactly as above.

## Structure
- **Package display_pkg** holds:
  - the FSM state enum (ST_IDLE, ST_PENDING)
  - the SEG_BLANK = 7'h7F constant
  - the 16-entry hex segment table constants
- **Sub-module hex7seg** is purely combinational: 4-bit nibble in, 7-bit active-low segments out.
- Everything else lives in display_out.

## Test plan
All scenarios use SCAN_DIV=4 and DIGITS=4.
- **Reset:** rst=0 for 3 cycles, then 1. an=4'b1111 during reset. After release, seg=7F on every slot and wr_ready=1.
- **Basic write:** write 16'h1A8F with mask 4'hF. Within 17 cycles the scan shows:
  - an=1110 → seg 0001110
  - an=1101 → 0000000
  - an=1011 → 0001000
  - an=0111 → 1111001
- **No tearing:** write 16'h0000, then 16'h8888 while PENDING. wr_ready stays 0 and no digit shows 8 before the first commit. After wr_ready returns to 1, resubmit 16'h8888; it commits at the next frame boundary.
- **Write on frame_end:** accept a write in the frame_end cycle. disp updates 16 cycles later, not 0.
- **Mask:** write 16'h1234 with mask 4'b0101. Digits 1 and 3 show 7F while an still scans all four.
- **Reset mid-PENDING:** accept 16'hFFFF, then assert rst before frame_end. After release the display is blank and wr_ready=1. With DISP_BLINK_EN, blink=4'b0001 makes digit 0 blank for frames 128..255.
